// File: rtl/vm1_pkg.sv
// rtl/vm1_pkg.sv - shared state encoding and window defaults for the vm1 memory bridge
package vm1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RPLY = 2'd2,
        ST_DONE = 2'd3
    } vm1_state_e;

    localparam logic [15:0] VM1_BASE_DEFAULT = 16'h0000;
    localparam logic [15:0] VM1_MASK_DEFAULT = 16'h8000;

endpackage

// File: rtl/vm1_mem_bridge.sv
// rtl/vm1_mem_bridge.sv - vm1 bus phase to single-request memory port bridge
module vm1_mem_bridge
    import vm1_pkg::*;
#(
    parameter logic [15:0] BASE = VM1_BASE_DEFAULT,
    parameter logic [15:0] MASK = VM1_MASK_DEFAULT
) (
    input  logic        pin_clk,
    input  logic        pin_reset_n,
    input  logic [15:0] pin_addr,
    input  logic [15:0] pin_dout,
    input  logic        pin_sync,
    input  logic        pin_stb,
    input  logic        pin_we,
    input  logic [1:0]  pin_wtbt,
    output logic [15:0] pin_din,
    output logic        pin_rply,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    vm1_state_e state, state_nxt;
    logic       served;
    logic       win_sel;
    logic       start;
    logic       ack_in_req;

    assign win_sel    = (pin_addr & MASK) == BASE;
    assign ack_in_req = (state == ST_REQ) && mem_ack;

    always_ff @(posedge pin_clk or negedge pin_reset_n) begin
        if (!pin_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // served clears only once pin_stb is low, so a stb level held across reset is not a new phase
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pin_sync && pin_stb && win_sel && !served) begin
                    start     = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_nxt = (!served || !pin_stb) ? ST_DONE : ST_RPLY;
                end
            end
            ST_RPLY: begin
                if (!pin_stb) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pin_clk or negedge pin_reset_n) begin
        if (!pin_reset_n) begin
            served    <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            pin_din   <= '0;
            pin_rply  <= 1'b0;
        end else begin
            if (start) begin
                served <= 1'b1;
            end else if (!pin_stb) begin
                served <= 1'b0;
            end

            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= pin_we;
                mem_addr  <= pin_addr[15:1];
                mem_be    <= pin_we ? pin_wtbt : 2'b11;
                mem_wdata <= pin_dout;
            end else if (ack_in_req) begin
                mem_req <= 1'b0;
            end

            if (ack_in_req && !mem_we) begin
                pin_din <= mem_rdata;
            end

            pin_rply <= (state_nxt == ST_RPLY);
        end
    end

endmodule

// File: tb/tb_vm1_mem_bridge.sv
// tb/tb_vm1_mem_bridge.sv - directed self-checking bench for vm1_mem_bridge
module tb_vm1_mem_bridge;

    logic        pin_clk = 1'b0;
    logic        pin_reset_n = 1'b0;
    logic [15:0] pin_addr = '0;
    logic [15:0] pin_dout = '0;
    logic        pin_sync = 1'b0;
    logic        pin_stb = 1'b0;
    logic        pin_we = 1'b0;
    logic [1:0]  pin_wtbt = '0;
    logic [15:0] pin_din;
    logic        pin_rply;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;
    int req_cnt = 0;
    int rply_cnt = 0;
    logic req_prev = 1'b0;
    logic rply_prev = 1'b0;

    vm1_mem_bridge dut (
        .pin_clk     (pin_clk),
        .pin_reset_n (pin_reset_n),
        .pin_addr    (pin_addr),
        .pin_dout    (pin_dout),
        .pin_sync    (pin_sync),
        .pin_stb     (pin_stb),
        .pin_we      (pin_we),
        .pin_wtbt    (pin_wtbt),
        .pin_din     (pin_din),
        .pin_rply    (pin_rply),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 pin_clk = ~pin_clk;

    always @(posedge pin_clk) begin
        req_prev  <= mem_req;
        rply_prev <= pin_rply;
        if (mem_req && !req_prev) req_cnt <= req_cnt + 1;
        if (pin_rply && !rply_prev) rply_cnt <= rply_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pin_clk);
    endtask

    task automatic test_reset;
        cyc(1);
        n_checks++;
        if ({mem_req, mem_we, pin_rply} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000", {mem_req, mem_we, pin_rply});
        end
        n_checks++;
        if ({mem_addr, mem_be, mem_wdata, pin_din} !== 49'd0) begin
            n_fail++; $display("FAIL reset_data: addr %h be %b wdata %h din %h want all 0", mem_addr, mem_be, mem_wdata, pin_din);
        end
        pin_reset_n = 1'b1;
        cyc(3);
    endtask

    task automatic test_read;
        int r0;
        r0 = rply_cnt;
        pin_addr = 16'h0100; pin_we = 1'b0; pin_wtbt = 2'b00; pin_sync = 1'b1; pin_stb = 1'b1;
        cyc(1);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_be, pin_rply} !== {1'b1, 1'b0, 15'h0080, 2'b11, 1'b0}) begin
            n_fail++; $display("FAIL read_req: req %b we %b addr %h be %b rply %b want 1 0 0080 11 0", mem_req, mem_we, mem_addr, mem_be, pin_rply);
        end
        cyc(2);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0080 || pin_rply !== 1'b0) begin
            n_fail++; $display("FAIL read_hold: req %b addr %h rply %b want 1 0080 0", mem_req, mem_addr, pin_rply);
        end
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        cyc(1);
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        n_checks++;
        if ({mem_req, pin_rply, pin_din} !== {1'b0, 1'b1, 16'hA5A5}) begin
            n_fail++; $display("FAIL read_done: req %b rply %b din %h want 0 1 a5a5", mem_req, pin_rply, pin_din);
        end
        cyc(3);
        n_checks++;
        if (pin_rply !== 1'b1) begin
            n_fail++; $display("FAIL read_rply_held: got %b want 1", pin_rply);
        end
        pin_stb = 1'b0;
        cyc(1);
        n_checks++;
        if (pin_rply !== 1'b0) begin
            n_fail++; $display("FAIL read_rply_drop: got %b want 0", pin_rply);
        end
        pin_sync = 1'b0;
        cyc(3);
        n_checks++;
        if (pin_din !== 16'hA5A5 || rply_cnt - r0 !== 1) begin
            n_fail++; $display("FAIL read_after: din %h rplys %0d want a5a5 1", pin_din, rply_cnt - r0);
        end
    endtask

    task automatic test_byte_write;
        int q0;
        q0 = req_cnt;
        pin_addr = 16'h0101; pin_we = 1'b1; pin_wtbt = 2'b10; pin_dout = 16'h3C00; pin_sync = 1'b1; pin_stb = 1'b1;
        cyc(1);
        n_checks++;
        if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 1'b1, 2'b10, 16'h3C00, 15'h0080}) begin
            n_fail++; $display("FAIL bw_req: req %b we %b be %b wdata %h addr %h want 1 1 10 3c00 0080", mem_req, mem_we, mem_be, mem_wdata, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        cyc(1);
        mem_ack = 1'b0;
        n_checks++;
        if ({pin_rply, mem_req} !== 2'b10) begin
            n_fail++; $display("FAIL bw_latency: rply %b req %b want 1 0", pin_rply, mem_req);
        end
        n_checks++;
        if (pin_din !== 16'hA5A5) begin
            n_fail++; $display("FAIL bw_din_kept: got %h want a5a5", pin_din);
        end
        pin_stb = 1'b0;
        cyc(2);
        pin_sync = 1'b0;
        cyc(2);
        n_checks++;
        if (req_cnt - q0 !== 1 || pin_rply !== 1'b0) begin
            n_fail++; $display("FAIL bw_count: reqs %0d rply %b want 1 0", req_cnt - q0, pin_rply);
        end
    endtask

    task automatic test_rmw;
        int q0, r0;
        q0 = req_cnt; r0 = rply_cnt;
        pin_addr = 16'h0200; pin_we = 1'b0; pin_wtbt = 2'b00; pin_sync = 1'b1; pin_stb = 1'b1;
        cyc(1);
        mem_ack = 1'b1; mem_rdata = 16'h0001;
        cyc(1);
        mem_ack = 1'b0;
        n_checks++;
        if (pin_rply !== 1'b1 || pin_din !== 16'h0001) begin
            n_fail++; $display("FAIL rmw_read: rply %b din %h want 1 0001", pin_rply, pin_din);
        end
        pin_stb = 1'b0;
        cyc(2);
        pin_we = 1'b1; pin_wtbt = 2'b11; pin_dout = 16'h0002; pin_stb = 1'b1;
        cyc(1);
        n_checks++;
        if ({mem_req, mem_we, mem_wdata, mem_be, mem_addr} !== {1'b1, 1'b1, 16'h0002, 2'b11, 15'h0100}) begin
            n_fail++; $display("FAIL rmw_write_req: req %b we %b wdata %h be %b addr %h want 1 1 0002 11 0100", mem_req, mem_we, mem_wdata, mem_be, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        cyc(1);
        mem_ack = 1'b0;
        pin_stb = 1'b0;
        cyc(2);
        pin_sync = 1'b0;
        cyc(2);
        n_checks++;
        if (req_cnt - q0 !== 2 || rply_cnt - r0 !== 2 || pin_din !== 16'h0001) begin
            n_fail++; $display("FAIL rmw_counts: reqs %0d rplys %0d din %h want 2 2 0001", req_cnt - q0, rply_cnt - r0, pin_din);
        end
    endtask

    task automatic test_unselected;
        int bad;
        bad = 0;
        pin_addr = 16'h8000; pin_we = 1'b0; pin_sync = 1'b1; pin_stb = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (mem_req || pin_rply) bad++;
        end
        mem_ack = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL unselected: %0d active cycles want 0", bad);
        end
        pin_stb = 1'b0; pin_sync = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_mid;
        int q0;
        pin_addr = 16'h0100; pin_we = 1'b0; pin_sync = 1'b1; pin_stb = 1'b1;
        cyc(1);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: req %b want 1", mem_req);
        end
        pin_reset_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, pin_rply, mem_addr, pin_din} !== 33'd0) begin
            n_fail++; $display("FAIL rst_mid_async: req %b rply %b addr %h din %h want 0 0 0 0", mem_req, pin_rply, mem_addr, pin_din);
        end
        cyc(2);
        pin_reset_n = 1'b1;
        q0 = req_cnt;
        cyc(6);
        n_checks++;
        if (req_cnt - q0 !== 0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_nostart: reqs %0d req %b want 0 0", req_cnt - q0, mem_req);
        end
        pin_stb = 1'b0;
        cyc(1);
        pin_stb = 1'b1;
        cyc(1);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_restart: req %b want 1", mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        cyc(1);
        mem_ack = 1'b0;
        pin_stb = 1'b0;
        cyc(2);
        pin_sync = 1'b0;
        cyc(1);
    endtask

    task automatic test_stb_abort;
        int r0;
        int bad;
        r0 = rply_cnt; bad = 0;
        pin_addr = 16'h0100; pin_we = 1'b0; pin_sync = 1'b1; pin_stb = 1'b1;
        cyc(1);
        pin_stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (mem_req !== 1'b1 || pin_rply !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL abort_hold: %0d bad cycles want 0", bad);
        end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        cyc(1);
        mem_ack = 1'b0;
        pin_stb = 1'b1;
        n_checks++;
        if (mem_req !== 1'b0 || pin_rply !== 1'b0) begin
            n_fail++; $display("FAIL abort_ack: req %b rply %b want 0 0", mem_req, pin_rply);
        end
        cyc(1);
        n_checks++;
        if (mem_req !== 1'b0 || dut.state !== vm1_pkg::ST_IDLE) begin
            n_fail++; $display("FAIL abort_idle: req %b state %0d want 0 0", mem_req, dut.state);
        end
        cyc(1);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL abort_next: req %b want 1", mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        cyc(1);
        mem_ack = 1'b0;
        pin_stb = 1'b0;
        cyc(2);
        pin_sync = 1'b0;
        cyc(1);
        n_checks++;
        if (rply_cnt - r0 !== 1 || pin_din !== 16'h5555) begin
            n_fail++; $display("FAIL abort_rplys: rplys %0d din %h want 1 5555", rply_cnt - r0, pin_din);
        end
    endtask

    initial begin
        test_reset;
        test_read;
        test_byte_write;
        test_rmw;
        test_unselected;
        test_reset_mid;
        test_stb_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
